exec_sequencer: RTL and testbench

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

---
 rtl/exec_seq_pkg.sv | 13 +
 rtl/perf_counter.sv | 9 +
 rtl/exec_sequencer.sv | 66 ++++++
 tb/tb_exec_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/exec_seq_pkg.sv
// exec_seq_pkg: shared state encoding and reset constants for the execution sequencer
package exec_seq_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_REQ,
    S_FETCH_WAIT,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
endpackage

// File: rtl/perf_counter.sv
// perf_counter: 64-bit wrapping event counter with enable and synchronous clear
module perf_counter (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  output logic [63:0] count
);
  always_ff @(posedge clk) count <= clr ? '0 : count + 64'(en);
endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: fetch/execute/writeback sequencer with sticky halt and perf counters
module exec_sequencer #(
  parameter logic [31:0] RESET_PC = exec_seq_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = exec_seq_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  output logic [31:0] ifu_req_addr,
  input  logic        ifu_req_ready,
  input  logic        ifu_resp_valid,
  input  logic [31:0] ifu_resp_inst,
  output logic        ifu_resp_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        dec_wen,
  input  logic        dec_ebreak,
  input  logic        dec_illegal,
  output logic        rf_wen,
  output logic        retire,
  output logic        halt,
  output logic        halt_bad,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret
);
  import exec_seq_pkg::*;
  state_t state;
  logic   wen_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      inst     <= NOP_INST;
      wen_q    <= 1'b0;
      halt_bad <= 1'b0;
    end else begin
      case (state)
        S_IDLE:       state <= S_FETCH_REQ;
        S_FETCH_REQ:  if (ifu_req_ready) state <= S_FETCH_WAIT;
        S_FETCH_WAIT: if (ifu_resp_valid) begin
          inst  <= ifu_resp_inst;
          state <= S_EXEC;
        end
        S_EXEC: begin
          state    <= (dec_illegal || dec_ebreak) ? S_HALT : S_WB;
          halt_bad <= dec_illegal;
          wen_q    <= dec_wen;
        end
        S_WB: begin
          pc    <= pc + 32'd4;
          state <= S_FETCH_REQ;
        end
        default: ;
      endcase
    end
  end
  // every output below is a decode of registered state, never of an input
  assign ifu_req_valid  = state == S_FETCH_REQ;
  assign ifu_req_addr   = pc;
  assign ifu_resp_ready = state == S_FETCH_WAIT;
  assign retire         = state == S_WB;
  assign rf_wen         = retire && wen_q;
  assign halt           = state == S_HALT;
  perf_counter u_cycle (.clk(clk), .clr(rst), .en(!halt), .count(cycle_cnt));
  perf_counter u_instret (.clk(clk), .clr(rst), .en(retire), .count(instret));
endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: randomized transaction-level check of exec_sequencer against a cycle budget model
module tb_exec_sequencer;
  localparam logic [31:0] RPC  = 32'h8000_0000;
  localparam logic [31:0] WPC  = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h0010_0093;
  logic        clk = 0, rst = 1;
  logic        ifu_req_ready = 0, ifu_resp_valid = 0;
  logic [31:0] ifu_resp_inst = 0;
  logic        dec_wen = 0, dec_ebreak = 0, dec_illegal = 0;
  logic        ifu_req_valid, ifu_resp_ready, rf_wen, retire, halt, halt_bad;
  logic [31:0] ifu_req_addr, inst, pc;
  logic [63:0] cycle_cnt, instret;
  logic        w_req_valid, w_resp_ready, w_rf_wen, w_retire, w_halt, w_halt_bad;
  logic [31:0] w_addr, w_inst, w_pc;
  logic [63:0] w_cycle, w_instret;
  int checks = 0, errors = 0;
  logic [31:0] exp_pc, wexp_pc, exp_inst;
  logic [63:0] cyc, ret;
  bit          m_halt;

  always #5 clk = ~clk;

  exec_sequencer dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr), .ifu_req_ready(ifu_req_ready),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_inst(ifu_resp_inst), .ifu_resp_ready(ifu_resp_ready),
    .inst(inst), .pc(pc), .dec_wen(dec_wen), .dec_ebreak(dec_ebreak), .dec_illegal(dec_illegal),
    .rf_wen(rf_wen), .retire(retire), .halt(halt), .halt_bad(halt_bad),
    .cycle_cnt(cycle_cnt), .instret(instret)
  );

  exec_sequencer #(.RESET_PC(WPC)) u_wrap (
    .clk(clk), .rst(rst),
    .ifu_req_valid(w_req_valid), .ifu_req_addr(w_addr), .ifu_req_ready(ifu_req_ready),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_inst(ifu_resp_inst), .ifu_resp_ready(w_resp_ready),
    .inst(w_inst), .pc(w_pc), .dec_wen(dec_wen), .dec_ebreak(dec_ebreak), .dec_illegal(dec_illegal),
    .rf_wen(w_rf_wen), .retire(w_retire), .halt(w_halt), .halt_bad(w_halt_bad),
    .cycle_cnt(w_cycle), .instret(w_instret)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    if (!m_halt) cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_dec();
    dec_wen = 1'($urandom);
    dec_ebreak = 1'($urandom);
    dec_illegal = 1'($urandom);
  endtask

  task automatic chk_common();
    chk("inst_hold", inst, exp_inst);
    chk("pc", pc, exp_pc);
    chk("wrap_pc", w_pc, wexp_pc);
    chk("cycle_cnt", cycle_cnt, cyc);
    chk("instret", instret, ret);
  endtask

  task automatic do_reset();
    rst = 1;
    ifu_req_ready = 1;
    ifu_resp_valid = 1;
    ifu_resp_inst = $urandom;
    rand_dec();
    step();
    cyc = 0; ret = 0; m_halt = 0;
    exp_pc = RPC; wexp_pc = WPC; exp_inst = NOP;
    chk("rst_req_valid", ifu_req_valid, 0);
    chk("rst_resp_ready", ifu_resp_ready, 0);
    chk("rst_retire", retire, 0);
    chk("rst_rf_wen", rf_wen, 0);
    chk("rst_halt", halt, 0);
    chk("rst_halt_bad", halt_bad, 0);
    chk_common();
    rst = 0;
    step();
  endtask

  task automatic run_inst(input int rdly, input int vdly, input logic [31:0] word,
                          input logic il, input logic eb, input logic wen);
    for (int i = 0; i <= rdly; i++) begin
      ifu_req_ready = (i == rdly);
      ifu_resp_valid = 1'($urandom);
      ifu_resp_inst = $urandom;
      rand_dec();
      chk("req_valid", ifu_req_valid, 1);
      chk("req_addr", ifu_req_addr, exp_pc);
      chk("wrap_addr", w_addr, wexp_pc);
      chk("req_resp_ready", ifu_resp_ready, 0);
      chk("req_retire", retire, 0);
      chk_common();
      step();
    end
    for (int i = 0; i <= vdly; i++) begin
      ifu_req_ready = 1'($urandom);
      ifu_resp_valid = (i == vdly);
      ifu_resp_inst = (i == vdly) ? word : $urandom;
      rand_dec();
      chk("wait_resp_ready", ifu_resp_ready, 1);
      chk("wait_req_valid", ifu_req_valid, 0);
      chk("wait_rf_wen", rf_wen, 0);
      chk_common();
      step();
    end
    exp_inst = word;
    ifu_resp_valid = 1;
    ifu_resp_inst = ~word;
    dec_illegal = il; dec_ebreak = eb; dec_wen = wen;
    chk("exec_req_valid", ifu_req_valid, 0);
    chk("exec_resp_ready", ifu_resp_ready, 0);
    chk("exec_retire", retire, 0);
    chk("exec_halt", halt, 0);
    chk_common();
    step();
    rand_dec();
    if (il || eb) begin
      m_halt = 1;
      for (int i = 0; i < 3; i++) begin
        ifu_req_ready = 1'($urandom);
        ifu_resp_valid = 1'($urandom);
        chk("halt", halt, 1);
        chk("halt_bad", halt_bad, il);
        chk("halt_retire", retire, 0);
        chk("halt_rf_wen", rf_wen, 0);
        chk("halt_req_valid", ifu_req_valid, 0);
        chk("halt_resp_ready", ifu_resp_ready, 0);
        chk_common();
        step();
      end
    end else begin
      chk("wb_retire", retire, 1);
      chk("wb_rf_wen", rf_wen, wen);
      chk("wb_halt", halt, 0);
      chk_common();
      step();
      exp_pc += 4; wexp_pc += 4; ret++;
    end
  endtask

  task automatic reset_mid_fetch();
    ifu_req_ready = 1;
    ifu_resp_valid = 0;
    chk("mf_req_valid", ifu_req_valid, 1);
    step();
    chk("mf_resp_ready", ifu_resp_ready, 1);
    do_reset();
  endtask

  initial begin
    m_halt = 0; cyc = 0; ret = 0;
    exp_pc = RPC; wexp_pc = WPC; exp_inst = NOP;
    step();
    do_reset();
    run_inst(0, 0, ADDI, 0, 0, 1);
    chk("zw_pc", pc, 32'h8000_0004);
    chk("zw_instret", instret, 1);
    chk("wrap_pc_zero", w_pc, 0);
    chk("wrap_addr_zero", w_addr, 0);
    run_inst(3, 2, ADDI, 0, 0, 1);
    reset_mid_fetch();
    run_inst(0, 0, 32'h0010_0073, 0, 1, 0);
    do_reset();
    run_inst(1, 1, 32'hFFFF_FFFF, 1, 1, 0);
    do_reset();
    for (int n = 0; n < 60; n++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k == 2) reset_mid_fetch();
      else begin
        run_inst($urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                 k == 0, k == 1 || (k == 0 && 1'($urandom)), 1'($urandom));
        if (m_halt) do_reset();
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
